// File: rtl/datapath_pkg.sv
// Shared definitions for the fetch stage that feeds the S1 decode register.
// The drain length follows the number of stages behind fetch (S1, S2, S3).
package datapath_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fetch_state_t;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_WORD_DEF = 32'h0000_0000;
   localparam int PIPE_STAGES = 3;
   localparam int DRAIN_CYCLES_DEF = PIPE_STAGES;

endpackage

// File: rtl/instr_mem.sv
// Program memory: single write port, asynchronous read, contents survive reset.
module instr_mem
   import datapath_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6,
   parameter int WIDTH  = INSTR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: program memory, PC and run/stall/drain FSM driving InstrIn of S1.
// After the last word it issues NOPs so the downstream stages retire before done.
module instr_fetch
   import datapath_pkg::*;
#(
   parameter int DEPTH        = 64,
   parameter int ADDR_W       = 6,
   parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEF,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_en,
   input  logic [ADDR_W-1:0]  load_addr,
   input  logic [INSTR_W-1:0] load_data,
   input  logic [ADDR_W:0]    prog_len,
   input  logic               start,
   input  logic               stall,
   output logic [INSTR_W-1:0] InstrOut,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  pc,
   output logic               busy,
   output logic               done
);

   localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYCLES);
   localparam logic [ADDR_W:0]   DEPTH_LEN  = (ADDR_W + 1)'(DEPTH);

   function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] len);
      return (len > DEPTH_LEN) ? DEPTH_LEN : len;
   endfunction

   fetch_state_t       state_q, state_d;
   logic [ADDR_W:0]    pc_q, pc_d;
   logic [ADDR_W:0]    len_q, len_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [INSTR_W-1:0] instr_p0, instr_d;
   logic               vld_p0, vld_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               mem_we;
   logic [INSTR_W-1:0] rd_data;
   logic [ADDR_W:0]    start_len;

   instr_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (INSTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (pc_q[ADDR_W-1:0]),
      .rdata (rd_data)
   );

   assign start_len = sat_len(prog_len);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      instr_d = instr_p0;
      vld_d   = vld_p0;
      mem_we  = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            mem_we = load_en;
            if (start) begin
               len_d = start_len;
               pc_d  = '0;
               if (start_len != '0) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_DRAIN;
                  cnt_d   = '0;
               end
            end
         end
         ST_RUN: begin
            // Full-width compare lets a DEPTH-long program end without refetching word 0.
            if (!stall) begin
               if (pc_q == len_q) begin
                  instr_d = NOP_WORD;
                  vld_d   = 1'b0;
                  cnt_d   = CNT_W'(1);
                  state_d = ST_DRAIN;
               end else begin
                  instr_d = rd_data;
                  vld_d   = 1'b1;
                  pc_d    = pc_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (!stall) begin
               instr_d = NOP_WORD;
               vld_d   = 1'b0;
               if (cnt_q == DRAIN_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   // Stage p0: state, PC and the InstrIn register of S1
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         instr_p0 <= NOP_WORD;
         vld_p0   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         instr_p0 <= instr_d;
         vld_p0   <= vld_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign InstrOut    = instr_p0;
   assign instr_valid = vld_p0;
   assign pc          = pc_q[ADDR_W-1:0];
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for run/stall/empty programs,
// hand sequences for load-during-run, mid-run reset and a full-depth program.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_en;
   logic [5:0]  load_addr;
   logic [31:0] load_data;
   logic [6:0]  prog_len;
   logic        start;
   logic        stall;
   logic [31:0] InstrOut;
   logic        instr_valid;
   logic [5:0]  pc;
   logic        busy;
   logic        done;

   int nvec = 0;
   int nerr = 0;

   instr_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .prog_len    (prog_len),
      .start       (start),
      .stall       (stall),
      .InstrOut    (InstrOut),
      .instr_valid (instr_valid),
      .pc          (pc),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic        stall;
      logic [6:0]  len;
      logic [31:0] instr;
      logic        vld;
      logic [5:0]  pc;
      logic        busy;
      logic        done;
   } vec_t;

   vec_t tbl[25];

   function automatic vec_t mk(logic st, logic sl, logic [6:0] ln, logic [31:0] ins,
                               logic v, logic [5:0] p, logic b, logic d);
      vec_t r;
      r.start = st; r.stall = sl; r.len = ln; r.instr = ins;
      r.vld = v; r.pc = p; r.busy = b; r.done = d;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [5:0] a, input logic [31:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      step();
      load_en = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!done && n < 200) begin
         step();
         n++;
      end
      chk(name, {31'd0, done}, 32'd1);
   endtask

   initial begin
      // Test 1: 4-word program; Test 2: same with 2-cycle stall on 0x22; Test 3: empty program
      tbl[0]  = mk(1, 0, 4, 32'h00, 0, 0, 1, 0);
      tbl[1]  = mk(0, 0, 4, 32'h11, 1, 1, 1, 0);
      tbl[2]  = mk(0, 0, 4, 32'h22, 1, 2, 1, 0);
      tbl[3]  = mk(0, 0, 4, 32'h33, 1, 3, 1, 0);
      tbl[4]  = mk(0, 0, 4, 32'h44, 1, 4, 1, 0);
      tbl[5]  = mk(0, 0, 4, 32'h00, 0, 4, 1, 0);
      tbl[6]  = mk(0, 0, 4, 32'h00, 0, 4, 1, 0);
      tbl[7]  = mk(0, 0, 4, 32'h00, 0, 4, 1, 0);
      tbl[8]  = mk(0, 0, 4, 32'h00, 0, 4, 0, 1);
      tbl[9]  = mk(1, 0, 4, 32'h00, 0, 0, 1, 0);
      tbl[10] = mk(0, 0, 4, 32'h11, 1, 1, 1, 0);
      tbl[11] = mk(0, 0, 4, 32'h22, 1, 2, 1, 0);
      tbl[12] = mk(0, 1, 4, 32'h22, 1, 2, 1, 0);
      tbl[13] = mk(0, 1, 4, 32'h22, 1, 2, 1, 0);
      tbl[14] = mk(0, 0, 4, 32'h33, 1, 3, 1, 0);
      tbl[15] = mk(0, 0, 4, 32'h44, 1, 4, 1, 0);
      tbl[16] = mk(0, 0, 4, 32'h00, 0, 4, 1, 0);
      tbl[17] = mk(0, 0, 4, 32'h00, 0, 4, 1, 0);
      tbl[18] = mk(0, 0, 4, 32'h00, 0, 4, 1, 0);
      tbl[19] = mk(0, 0, 4, 32'h00, 0, 4, 0, 1);
      tbl[20] = mk(1, 0, 0, 32'h00, 0, 0, 1, 0);
      tbl[21] = mk(0, 0, 0, 32'h00, 0, 0, 1, 0);
      tbl[22] = mk(0, 0, 0, 32'h00, 0, 0, 1, 0);
      tbl[23] = mk(0, 0, 0, 32'h00, 0, 0, 1, 0);
      tbl[24] = mk(0, 0, 0, 32'h00, 0, 0, 0, 1);

      rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
      prog_len = '0; start = 1'b0; stall = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("rst instr", InstrOut, 32'h0);
      chk("rst valid", {31'd0, instr_valid}, 32'd0);
      chk("rst pc", {26'd0, pc}, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);

      load_word(6'd0, 32'h11);
      load_word(6'd1, 32'h22);
      load_word(6'd2, 32'h33);
      load_word(6'd3, 32'h44);

      for (int i = 0; i < 25; i++) begin
         start = tbl[i].start; stall = tbl[i].stall; prog_len = tbl[i].len;
         step();
         start = 1'b0; stall = 1'b0;
         chk($sformatf("row%0d instr", i), InstrOut, tbl[i].instr);
         chk($sformatf("row%0d valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].vld});
         chk($sformatf("row%0d pc", i), {26'd0, pc}, {26'd0, tbl[i].pc});
         chk($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
         chk($sformatf("row%0d done", i), {31'd0, done}, {31'd0, tbl[i].done});
      end

      // Test 4: write to address 1 while running must be dropped
      prog_len = 7'd4; start = 1'b1;
      step();
      start = 1'b0;
      load_en = 1'b1; load_addr = 6'd1; load_data = 32'hDEAD;
      step();
      chk("ldrun w0", InstrOut, 32'h11);
      step();
      chk("ldrun w1", InstrOut, 32'h22);
      step();
      load_en = 1'b0;
      wait_done("ldrun done");
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("rerun w0", InstrOut, 32'h11);
      step();
      chk("rerun w1", InstrOut, 32'h22);
      chk("rerun pc", {26'd0, pc}, 32'd2);

      // Test 5: reset in RUN at pc=2 aborts, then a fresh start refetches from 0
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort instr", InstrOut, 32'h0);
      chk("abort valid", {31'd0, instr_valid}, 32'd0);
      chk("abort pc", {26'd0, pc}, 32'd0);
      chk("abort busy", {31'd0, busy}, 32'd0);
      step();
      chk("abort idle", {31'd0, busy}, 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("restart w0", InstrOut, 32'h11);
      step();
      chk("restart w1", InstrOut, 32'h22);
      wait_done("restart done");

      // Test 6: full-depth program, each word equal to its address
      for (int k = 0; k < 64; k++) begin
         load_word(6'(k), 32'(k));
      end
      prog_len = 7'd64; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 64; k++) begin
         step();
         chk($sformatf("full w%0d", k), InstrOut, 32'(k));
         chk($sformatf("full v%0d", k), {31'd0, instr_valid}, 32'd1);
      end
      chk("full pc wrap", {26'd0, pc}, 32'd0);
      step();
      chk("full drain instr", InstrOut, 32'h0);
      chk("full drain valid", {31'd0, instr_valid}, 32'd0);
      chk("full drain busy", {31'd0, busy}, 32'd1);
      wait_done("full done");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
